// File: rtl/disp_pkg.sv
// Shared types and constants for the two-digit action/speed display scanner.
// Consumed by disp_scan_ctrl and scan_timer.
package disp_pkg;

  typedef enum logic [1:0] {
    BLANK_ACT,
    SHOW_ACT,
    BLANK_SPD,
    SHOW_SPD
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] DIG_OFF   = 2'b11;
  localparam int         ACT       = 0;
  localparam int         SPD       = 1;

endpackage

// File: rtl/scan_timer.sv
// Terminal-count counter with synchronous clear; strobes at the blank
// boundary and at the last count of a slot.
module scan_timer
  import disp_pkg::*;
#(
  parameter int TERM  = 10,
  parameter int BLANK = 1,
  parameter int W     = (TERM > 1) ? $clog2(TERM) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         blank_done_o,
  output logic         slot_done_o
);

  localparam logic [W-1:0] LAST  = W'(TERM - 1);
  localparam logic [W-1:0] BDONE = W'(BLANK - 1);

  logic [W-1:0] count_q, count_d;

  assign count_o      = count_q;
  assign blank_done_o = (count_q == BDONE);
  assign slot_done_o  = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (adv_i) begin
      count_d = slot_done_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Two-digit 7-seg scan driver with blanking gap at each digit switch.
// Optional speed-digit blink when DISP_BLINK_EN is defined.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seg_in,
`ifdef DISP_BLINK_EN
  input  logic       blink_spd,
`endif
  output logic       sel,
  output logic [1:0] dig_n,
  output logic [6:0] seg_out,
  output logic       frame_tick
);

  localparam int DWELL = CLK_HZ / REFRESH_HZ;
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(DWELL - 2);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL || BLINK_FRAMES < 1)
  begin : g_bad_cfg
    $error("disp_scan_ctrl: need 1 <= BLANK_CYCLES < DWELL");
  end

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic [1:0]    dig_q, dig_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick_q, tick_d;
  logic          cap;
  logic          spd_dark;
  logic [CW-1:0] cnt;
  logic          blank_done, slot_done;

  scan_timer #(
    .TERM (DWELL),
    .BLANK(BLANK_CYCLES),
    .W    (CW)
  ) u_slot (
    .clk,
    .rst_n,
    .adv_i       (en),
    .clr_i       (~en),
    .count_o     (cnt),
    .blank_done_o(blank_done),
    .slot_done_o (slot_done)
  );

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          phase_q, phase_d;
  logic          fr_wrap;
  logic [FW-1:0] fr_cnt_unused;
  logic          fr_blank_unused;

  scan_timer #(
    .TERM (BLINK_FRAMES),
    .BLANK(1),
    .W    (FW)
  ) u_frame (
    .clk,
    .rst_n,
    .adv_i       (tick_q),
    .clr_i       (~blink_spd),
    .count_o     (fr_cnt_unused),
    .blank_done_o(fr_blank_unused),
    .slot_done_o (fr_wrap)
  );

  always_comb begin
    phase_d = phase_q;
    if (!blink_spd)             phase_d = 1'b0;
    else if (tick_q && fr_wrap) phase_d = ~phase_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= 1'b0;
    else        phase_q <= phase_d;
  end

  assign spd_dark = blink_spd & phase_q;
`else
  assign spd_dark = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    if (!en) begin
      state_d = BLANK_ACT;
    end else begin
      unique case (state_q)
        BLANK_ACT: if (blank_done) begin
          cap     = 1'b1;
          state_d = SHOW_ACT;
        end
        SHOW_ACT:  if (slot_done) state_d = BLANK_SPD;
        BLANK_SPD: if (blank_done) begin
          cap     = 1'b1;
          state_d = SHOW_SPD;
        end
        SHOW_SPD:  if (slot_done) state_d = BLANK_ACT;
      endcase
    end
  end

  // Outputs decode the next state so they land with the state change.
  always_comb begin
    sel_d = (state_d == BLANK_SPD) || (state_d == SHOW_SPD);
    dig_d = DIG_OFF;
    if (state_d == SHOW_ACT)              dig_d[ACT] = 1'b0;
    if (state_d == SHOW_SPD && !spd_dark) dig_d[SPD] = 1'b0;
    seg_d  = !en ? SEG_BLANK : (cap ? seg_in : seg_q);
    tick_d = en && (state_d == SHOW_SPD) && (cnt == PRE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK_ACT;
      sel_q   <= 1'b0;
      dig_q   <= DIG_OFF;
      seg_q   <= SEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  assign sel        = sel_q;
  assign dig_n      = dig_q;
  assign seg_out    = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl (DWELL=10, BLANK_CYCLES=2).
// Blink checks are built only when DISP_BLINK_EN is defined.
module tb_disp_scan_ctrl;

  typedef struct {
    int         cyc;
    logic [1:0] dig;
    logic [6:0] seg;
    logic       sel;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] seg_in = 7'h40;
  logic       tog = 1'b0;
`ifdef DISP_BLINK_EN
  logic       blink_spd = 1'b0;
`endif
  logic       sel;
  logic [1:0] dig_n;
  logic [6:0] seg_out;
  logic       frame_tick;

  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   base;
  exp_t q[$];

  disp_scan_ctrl #(
    .CLK_HZ      (1000),
    .REFRESH_HZ  (100),
    .BLANK_CYCLES(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seg_in    (seg_in),
`ifdef DISP_BLINK_EN
    .blink_spd (blink_spd),
`endif
    .sel       (sel),
    .dig_n     (dig_n),
    .seg_out   (seg_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behaves like the action/speed mux while blanked, garbage while shown.
  always @(negedge clk) begin
    tog = ~tog;
    if (dig_n == 2'b11) seg_in = sel ? 7'h24 : 7'h40;
    else                seg_in = tog ? 7'h00 : 7'h5A;
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(int c, int r, bit blink);
    exp_t e;
    int   m;
    int   f;
    m      = r % 20;
    f      = r / 20;
    e.cyc  = c;
    e.sel  = (m >= 10);
    e.tick = (m == 19);
    if (m < 2 || (m >= 10 && m < 12)) e.dig = 2'b11;
    else if (m < 10)                  e.dig = 2'b10;
    else if (blink && (f / 2) % 2 == 1) e.dig = 2'b11;
    else                              e.dig = 2'b01;
    if (r < 2)                  e.seg = 7'h7F;
    else if (m >= 2 && m < 12)  e.seg = 7'h40;
    else                        e.seg = 7'h24;
    return e;
  endfunction

  task automatic push_run(int b, int n, bit blink);
    for (int r = 1; r <= n; r++) q.push_back(mk(b + r, r, blink));
  endtask

  task automatic push_blank(int c);
    exp_t e;
    e.cyc  = c;
    e.dig  = 2'b11;
    e.seg  = 7'h7F;
    e.sel  = 1'b0;
    e.tick = 1'b0;
    q.push_back(e);
  endtask

  task automatic goto(int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk($sformatf("missed@%0d", e.cyc), cyc, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk($sformatf("dig@%0d", cyc), dig_n, e.dig);
      chk($sformatf("sel@%0d", cyc), sel, e.sel);
      chk($sformatf("tick@%0d", cyc), frame_tick, e.tick);
      chk($sformatf("seg@%0d", cyc), seg_out, e.seg);
    end
  end

  logic [1:0] prev_dig = 2'b11;
  logic       prev_sel = 1'b0;

  always @(posedge clk) begin
    #1;
    chk("dig_excl", (dig_n == 2'b00), 0);
    if (prev_dig == 2'b11 && dig_n != 2'b11) begin
      chk("show_sel", sel, (dig_n == 2'b01));
      chk("show_seg", seg_out, (dig_n == 2'b01) ? 7'h24 : 7'h40);
    end
    if (sel != prev_sel) chk("sel_in_blank", dig_n, 2'b11);
    prev_dig = dig_n;
    prev_sel = sel;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dig", dig_n, 2'b11);
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_sel", sel, 0);
    chk("rst_tick", frame_tick, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_dig", dig_n, 2'b11);

    en   = 1'b1;
    base = cyc;
    push_run(base, 39, 1'b0);

    goto(base + 54);
    en = 1'b0;
    for (int c = 55; c <= 59; c++) push_blank(base + c);

    goto(base + 70);
    en   = 1'b1;
    base = cyc;
    push_run(base, 25, 1'b0);

    goto(base + 38);
    en = 1'b0;
    push_blank(base + 39);
    push_blank(base + 40);

    goto(base + 45);
    en   = 1'b1;
    base = cyc;
    push_run(base, 14, 1'b0);
    goto(base + 15);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dig", dig_n, 2'b11);
    chk("arst_seg", seg_out, 7'h7F);
    chk("arst_sel", sel, 0);
    chk("arst_tick", frame_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    push_run(base, 21, 1'b0);
    goto(base + 25);

    for (int i = 0; i < 10000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      @(negedge clk);
    end

`ifdef DISP_BLINK_EN
    en = 1'b0;
    repeat (2) @(negedge clk);
    en        = 1'b1;
    blink_spd = 1'b1;
    base      = cyc;
    push_run(base, 99, 1'b1);
    goto(base + 101);
    blink_spd = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
